// File: rtl/serial_difference_ctrl_if.sv
// Requester-side bundle for the bit-serial subtractor: start/ack handshake,
// operands and the registered result flags.
interface serial_difference_ctrl_if #(
    parameter int W = 4
);
    // Handshake: a request is accepted on a rising edge where start=1 and the
    // sequencer is idle, or where it is presenting a result and ack=1 in the
    // same cycle. A result is offered while done=1 and is retired by ack=1.
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ack;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;
    logic         overflow;

    modport master (
        output start, a, b, ack,
        input  busy, done, diff, borrow_out, zero, overflow
    );

    modport slave (
        input  start, a, b, ack,
        output busy, done, diff, borrow_out, zero, overflow
    );
endinterface

// File: rtl/serial_difference_ctrl.sv
// Bit-serial W-bit subtractor: one full-difference cell reused over W clocks,
// LSB first. Results are registered and only change when a subtraction ends.
module serial_difference_ctrl #(
    parameter int W = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    serial_difference_ctrl_if.slave   bus,
    output logic [1:0]                state_dbg
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_sr_q, a_sr_d;     // minuend bits; vacated MSBs collect difference bits
    logic [W-1:0]   b_sr_q, b_sr_d;
    logic           brw_q, brw_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           a_msb_q, a_msb_d;   // captured sign bits for the overflow flag
    logic           b_msb_q, b_msb_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           borrow_q, borrow_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           bit_s;
    logic           brw_nx;
    logic [W-1:0]   res_s;

    // Next-state, datapath step and result load for the three-state sequencer.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        bit_s  = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
        brw_nx = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
        // After the final step the shifted minuend register is exactly the difference.
        res_s  = {bit_s, a_sr_q[W-1:1]};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    a_msb_d = bus.a[W-1];
                    b_msb_d = bus.b[W-1];
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sr_d = res_s;
                b_sr_d = {1'b0, b_sr_q[W-1:1]};
                brw_d  = brw_nx;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    diff_d   = res_s;
                    borrow_d = brw_nx;
                    zero_d   = (res_s == '0);
                    ovf_d    = (a_msb_q != b_msb_q) && (res_s[W-1] != a_msb_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    if (bus.start) begin
                        state_d = RUN;
                        a_sr_d  = bus.a;
                        b_sr_d  = bus.b;
                        a_msb_d = bus.a[W-1];
                        b_msb_d = bus.b[W-1];
                        brw_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.zero       = zero_q;
    assign bus.overflow   = ovf_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_serial_difference_ctrl.sv
// Directed bench for the bit-serial subtractor at W=4 and W=5.
module tb_serial_difference_ctrl;
    logic clk;
    logic reset_n;
    logic [1:0] state_dbg4;
    logic [1:0] state_dbg5;

    int tests = 0;
    int fails = 0;

    logic [3:0] prev_diff4;

    serial_difference_ctrl_if #(.W(4)) if4 ();
    serial_difference_ctrl_if #(.W(5)) if5 ();

    serial_difference_ctrl #(.W(4)) u4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (if4),
        .state_dbg (state_dbg4)
    );

    serial_difference_ctrl #(.W(5)) u5 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (if5),
        .state_dbg (state_dbg5)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One W=4 subtraction from accept to retire, with optional protocol abuse during RUN.
    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ed,
                       input logic eb, input logic ez, input logic eo, input bit abuse);
        if4.a = av;
        if4.b = bv;
        if4.start = 1'b1;
        tick;                       // accepting edge t
        if4.start = 1'b0;
        if4.a = ~av;                // operands may change after capture
        if4.b = ~bv;
        chk("acc_busy", if4.busy, 1);
        chk("acc_done", if4.done, 0);
        for (int i = 1; i < 4; i++) begin
            if (abuse) begin
                if4.a     = 4'($urandom_range(0, 15));
                if4.b     = 4'($urandom_range(0, 15));
                if4.start = 1'($urandom_range(0, 1));
                if4.ack   = 1'b1;
            end
            tick;                   // edges t+1 .. t+3
            chk("run_busy", if4.busy, 1);
            chk("run_done", if4.done, 0);
            chk("run_hold_diff", if4.diff, prev_diff4);
        end
        if4.start = 1'b0;
        if4.ack   = 1'b0;
        tick;                       // edge t+4: result loaded
        chk("fin_busy", if4.busy, 0);
        chk("fin_done", if4.done, 1);
        chk("diff", if4.diff, ed);
        chk("borrow", if4.borrow_out, eb);
        chk("zero", if4.zero, ez);
        chk("overflow", if4.overflow, eo);
        // start without ack is ignored; done holds
        if4.start = 1'b1;
        if4.a = 4'h0;
        if4.b = 4'hF;
        tick;
        tick;
        chk("hold_done", if4.done, 1);
        chk("hold_busy", if4.busy, 0);
        chk("hold_diff", if4.diff, ed);
        if4.start = 1'b0;
        if4.ack = 1'b1;
        tick;
        if4.ack = 1'b0;
        chk("ret_done", if4.done, 0);
        chk("ret_busy", if4.busy, 0);
        chk("ret_diff", if4.diff, ed);
        chk("ret_borrow", if4.borrow_out, eb);
        chk("ret_ovf", if4.overflow, eo);
        prev_diff4 = ed;
    endtask

    initial begin
        reset_n = 1'b0;
        if4.start = 1'b0; if4.ack = 1'b0; if4.a = '0; if4.b = '0;
        if5.start = 1'b0; if5.ack = 1'b0; if5.a = '0; if5.b = '0;
        prev_diff4 = 4'h0;
        #3;
        chk("rst_busy", if4.busy, 0);
        chk("rst_done", if4.done, 0);
        chk("rst_diff", if4.diff, 0);
        chk("rst_borrow", if4.borrow_out, 0);
        chk("rst_zero", if4.zero, 0);
        chk("rst_ovf", if4.overflow, 0);
        chk("rst_busy5", if5.busy, 0);
        chk("rst_done5", if5.done, 0);
        tick;
        tick;
        reset_n = 1'b1;
        tick;

        // ack while idle does nothing
        if4.ack = 1'b1;
        tick;
        tick;
        if4.ack = 1'b0;
        chk("idle_ack_busy", if4.busy, 0);
        chk("idle_ack_done", if4.done, 0);

        // basic 5-3
        op4(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-RUN after two bits processed
        if4.a = 4'b1111;
        if4.b = 4'b0111;
        if4.start = 1'b1;
        tick;
        if4.start = 1'b0;
        tick;
        tick;
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_busy", if4.busy, 0);
        chk("mrst_done", if4.done, 0);
        chk("mrst_diff", if4.diff, 0);
        chk("mrst_borrow", if4.borrow_out, 0);
        chk("mrst_zero", if4.zero, 0);
        chk("mrst_ovf", if4.overflow, 0);
        tick;
        reset_n = 1'b1;
        prev_diff4 = 4'h0;
        tick;
        chk("mrst_idle", if4.busy, 0);
        op4(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

        // result table
        op4(4'b1111, 4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(4'b1001, 4'b0110, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
        op4(4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
        op4(4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        op4(4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // protocol abuse during RUN: 6-1
        op4(4'b0110, 4'b0001, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);

        // W=5 back-to-back: 22-3 then 9-6
        if5.a = 5'b10110;
        if5.b = 5'b00011;
        if5.start = 1'b1;
        tick;
        if5.start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("b2b_first_done", if5.done, 1);
        chk("b2b_first_diff", if5.diff, 5'b10011);
        chk("b2b_first_borrow", if5.borrow_out, 0);
        chk("b2b_first_ovf", if5.overflow, 0);
        if5.a = 5'b01001;
        if5.b = 5'b00110;
        if5.start = 1'b1;
        if5.ack = 1'b1;
        tick;
        if5.start = 1'b0;
        if5.ack = 1'b0;
        chk("b2b_busy", if5.busy, 1);
        chk("b2b_done", if5.done, 0);
        chk("b2b_hold_diff", if5.diff, 5'b10011);
        for (int i = 1; i < 5; i++) begin
            tick;
            chk("b2b_run_busy", if5.busy, 1);
            chk("b2b_run_diff", if5.diff, 5'b10011);
        end
        tick;
        chk("b2b_second_done", if5.done, 1);
        chk("b2b_second_busy", if5.busy, 0);
        chk("b2b_second_diff", if5.diff, 5'b00011);
        chk("b2b_second_borrow", if5.borrow_out, 0);
        chk("b2b_second_zero", if5.zero, 0);
        chk("b2b_second_ovf", if5.overflow, 0);
        if5.ack = 1'b1;
        tick;
        if5.ack = 1'b0;
        chk("b2b_ret_done", if5.done, 0);
        chk("b2b_ret_diff", if5.diff, 5'b00011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
